// File: rtl/ad_ip_jesd204_tpl_dac_pattern_channel_pkg.sv
// Shared codes and polynomial constants for the DAC
// transport-layer pattern channel.
package ad_ip_jesd204_tpl_dac_pattern_channel_pkg;

  localparam logic [3:0] SEL_DDS   = 4'd0;
  localparam logic [3:0] SEL_PAT   = 4'd1;
  localparam logic [3:0] SEL_DMA   = 4'd2;
  localparam logic [3:0] SEL_ZERO  = 4'd3;
  localparam logic [3:0] SEL_NPN7  = 4'd4;
  localparam logic [3:0] SEL_NPN15 = 4'd5;
  localparam logic [3:0] SEL_PN7   = 4'd6;
  localparam logic [3:0] SEL_PN15  = 4'd7;
  localparam logic [3:0] SEL_PN    = 4'd8;
  localparam logic [3:0] SEL_NPN   = 4'd9;
  localparam logic [3:0] SEL_RAMP  = 4'd10;

  localparam logic [2:0] PN_SEL_7  = 3'd0;
  localparam logic [2:0] PN_SEL_9  = 3'd1;
  localparam logic [2:0] PN_SEL_15 = 3'd2;
  localparam logic [2:0] PN_SEL_23 = 3'd3;
  localparam logic [2:0] PN_SEL_31 = 3'd4;

  // x^ORDER + x^TAP + 1
  localparam int PN7_ORDER  = 7;
  localparam int PN7_TAP    = 6;
  localparam int PN9_ORDER  = 9;
  localparam int PN9_TAP    = 5;
  localparam int PN15_ORDER = 15;
  localparam int PN15_TAP   = 14;
  localparam int PN23_ORDER = 23;
  localparam int PN23_TAP   = 18;
  localparam int PN31_ORDER = 31;
  localparam int PN31_TAP   = 28;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_pattern_channel_prbs.sv
// Parallel PRBS generator: WIDTH stream bits per cycle,
// oldest bit in data MSB.
module ad_ip_jesd204_tpl_dac_prbs #(
  parameter int POLY_ORDER = 7,
  parameter int TAP        = 6,
  parameter int WIDTH      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  output logic [WIDTH-1:0] data
);

  logic [POLY_ORDER-1:0] state;
  logic [POLY_ORDER-1:0] state_nxt;
  logic [WIDTH-1:0]      data_nxt;
  logic                  fb;

  // state[0] holds the newest bit
  always_comb begin
    state_nxt = state;
    data_nxt  = '0;
    fb        = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      fb = state_nxt[POLY_ORDER-1] ^ state_nxt[TAP-1];
      data_nxt[WIDTH-1-k] = fb;
      state_nxt = {state_nxt[POLY_ORDER-2:0], fb};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '1;
      data  <= '1;
    end else if (sync) begin
      state <= '1;
      data  <= '1;
    end else begin
      state <= state_nxt;
      data  <= data_nxt;
    end
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_pattern_channel.sv
// Per-converter DAC channel: registered source mux over
// DDS, DMA, pattern, ramp, zero and PRBS.
module ad_ip_jesd204_tpl_dac_pattern_channel
  import ad_ip_jesd204_tpl_dac_pattern_channel_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int SAMPLE_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_PATH_WIDTH*16-1:0] dma_data,
  input  logic                          dma_valid,
  output logic                          dma_ready,
  input  logic [DATA_PATH_WIDTH*16-1:0] dds_data,
  output logic [DATA_PATH_WIDTH*16-1:0] dac_data,
  input  logic                          dac_data_sync,
  input  logic [3:0]                    dac_data_sel,
  input  logic [2:0]                    dac_pn_sel,
  input  logic [15:0]                   dac_pat_data_0,
  input  logic [15:0]                   dac_pat_data_1,
  input  logic [15:0]                   dac_ramp_incr,
  input  logic                          dac_underflow_mode,
  input  logic                          dac_underflow_clr,
  output logic                          dac_underflow,
  output logic                          dac_enable
);

  localparam int W  = DATA_PATH_WIDTH * SAMPLE_WIDTH;
  localparam int DW = DATA_PATH_WIDTH * 16;
  localparam logic [15:0] LANE_MASK =
    16'hffff << (16 - SAMPLE_WIDTH);
  localparam logic [DW-1:0] MASK =
    {DATA_PATH_WIDTH{LANE_MASK}};

  logic [W-1:0]  pn7_bits;
  logic [W-1:0]  pn9_bits;
  logic [W-1:0]  pn15_bits;
  logic [W-1:0]  pn23_bits;
  logic [W-1:0]  pn31_bits;
  logic [W-1:0]  pn_bits;
  logic [DW-1:0] pn7_lanes;
  logic [DW-1:0] pn15_lanes;
  logic [DW-1:0] pn_lanes;
  logic [DW-1:0] pat_lanes;
  logic [DW-1:0] ramp_lanes;
  logic [DW-1:0] dma_lanes;
  logic [DW-1:0] hold;
  logic [DW-1:0] mux;
  logic [15:0]   base;
  logic          dma_xfer;
  logic          dma_miss;

  ad_ip_jesd204_tpl_dac_prbs #(
    .POLY_ORDER(PN7_ORDER), .TAP(PN7_TAP), .WIDTH(W)
  ) u_pn7 (
    .clk(clk), .rst(rst), .sync(dac_data_sync),
    .data(pn7_bits)
  );

  ad_ip_jesd204_tpl_dac_prbs #(
    .POLY_ORDER(PN9_ORDER), .TAP(PN9_TAP), .WIDTH(W)
  ) u_pn9 (
    .clk(clk), .rst(rst), .sync(dac_data_sync),
    .data(pn9_bits)
  );

  ad_ip_jesd204_tpl_dac_prbs #(
    .POLY_ORDER(PN15_ORDER), .TAP(PN15_TAP), .WIDTH(W)
  ) u_pn15 (
    .clk(clk), .rst(rst), .sync(dac_data_sync),
    .data(pn15_bits)
  );

  ad_ip_jesd204_tpl_dac_prbs #(
    .POLY_ORDER(PN23_ORDER), .TAP(PN23_TAP), .WIDTH(W)
  ) u_pn23 (
    .clk(clk), .rst(rst), .sync(dac_data_sync),
    .data(pn23_bits)
  );

  ad_ip_jesd204_tpl_dac_prbs #(
    .POLY_ORDER(PN31_ORDER), .TAP(PN31_TAP), .WIDTH(W)
  ) u_pn31 (
    .clk(clk), .rst(rst), .sync(dac_data_sync),
    .data(pn31_bits)
  );

  // Stream bit k -> sample k/SW, lane bit 15 - k%SW
  function automatic logic [DW-1:0] to_lanes(
    input logic [W-1:0] bits
  );
    logic [DW-1:0] r;
    r = '0;
    for (int s = 0; s < DATA_PATH_WIDTH; s++)
      for (int j = 0; j < SAMPLE_WIDTH; j++)
        r[s*16+15-j] = bits[W-1-(s*SAMPLE_WIDTH+j)];
    return r;
  endfunction

  always_comb begin
    pn_bits = pn7_bits;
    case (dac_pn_sel)
      PN_SEL_9:  pn_bits = pn9_bits;
      PN_SEL_15: pn_bits = pn15_bits;
      PN_SEL_23: pn_bits = pn23_bits;
      PN_SEL_31: pn_bits = pn31_bits;
      default:   pn_bits = pn7_bits;
    endcase
  end

  assign pn7_lanes  = to_lanes(pn7_bits);
  assign pn15_lanes = to_lanes(pn15_bits);
  assign pn_lanes   = to_lanes(pn_bits);

  always_comb begin
    pat_lanes  = '0;
    ramp_lanes = '0;
    for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
      pat_lanes[i*16+:16] =
        (i % 2 == 0) ? dac_pat_data_0 : dac_pat_data_1;
      ramp_lanes[i*16+:16] =
        base + 16'(i) * dac_ramp_incr;
    end
  end

  assign dma_ready = dac_enable;
  assign dma_xfer  = dma_ready & dma_valid;
  assign dma_miss  = dma_ready & ~dma_valid;
  assign dma_lanes = dma_xfer ? dma_data :
    (dac_underflow_mode ? hold : '0);

  always_comb begin
    mux = '0;
    case (dac_data_sel)
      SEL_DDS:   mux = dds_data;
      SEL_PAT:   mux = pat_lanes;
      SEL_DMA:   mux = dma_lanes;
      SEL_NPN7:  mux = ~pn7_lanes;
      SEL_NPN15: mux = ~pn15_lanes;
      SEL_PN7:   mux = pn7_lanes;
      SEL_PN15:  mux = pn15_lanes;
      SEL_PN:    mux = pn_lanes;
      SEL_NPN:   mux = ~pn_lanes;
      SEL_RAMP:  mux = ramp_lanes;
      default:   mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_data      <= '0;
      dac_enable    <= 1'b0;
      dac_underflow <= 1'b0;
      hold          <= '0;
      base          <= '0;
    end else begin
      dac_data   <= mux & MASK;
      dac_enable <= (dac_data_sel == SEL_DMA);
      if (dma_xfer)
        hold <= dma_data;
      if (dma_miss)
        dac_underflow <= 1'b1;
      else if (dac_underflow_clr)
        dac_underflow <= 1'b0;
      if (dac_data_sync)
        base <= '0;
      else
        base <= base +
          16'(DATA_PATH_WIDTH) * dac_ramp_incr;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_pattern_channel.sv
// Self-checking bench: 16-bit and 12-bit channel instances
// against a stream/arithmetic reference model.
`timescale 1ns/1ps
module tb_ad_ip_jesd204_tpl_dac_pattern_channel;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] dma_data = '0;
  logic        dma_valid = 1'b0;
  logic [63:0] dds_data = '0;
  logic        sync = 1'b0;
  logic [3:0]  sel = 4'd3;
  logic [2:0]  pn_sel = 3'd0;
  logic [15:0] pat0 = '0;
  logic [15:0] pat1 = '0;
  logic [15:0] incr = '0;
  logic        uf_mode = 1'b0;
  logic        uf_clr = 1'b0;

  logic [63:0] dac16, dac12;
  logic        rdy16, rdy12, uf16, uf12, en16, en12;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_pattern_channel #(
    .DATA_PATH_WIDTH(4), .SAMPLE_WIDTH(16)
  ) u_dut (
    .clk(clk), .rst(rst),
    .dma_data(dma_data), .dma_valid(dma_valid),
    .dma_ready(rdy16), .dds_data(dds_data),
    .dac_data(dac16), .dac_data_sync(sync),
    .dac_data_sel(sel), .dac_pn_sel(pn_sel),
    .dac_pat_data_0(pat0), .dac_pat_data_1(pat1),
    .dac_ramp_incr(incr),
    .dac_underflow_mode(uf_mode),
    .dac_underflow_clr(uf_clr),
    .dac_underflow(uf16), .dac_enable(en16)
  );

  ad_ip_jesd204_tpl_dac_pattern_channel #(
    .DATA_PATH_WIDTH(4), .SAMPLE_WIDTH(12)
  ) u_dut12 (
    .clk(clk), .rst(rst),
    .dma_data(dma_data), .dma_valid(dma_valid),
    .dma_ready(rdy12), .dds_data(dds_data),
    .dac_data(dac12), .dac_data_sync(sync),
    .dac_data_sel(sel), .dac_pn_sel(pn_sel),
    .dac_pat_data_0(pat0), .dac_pat_data_1(pat1),
    .dac_ramp_incr(incr),
    .dac_underflow_mode(uf_mode),
    .dac_underflow_clr(uf_clr),
    .dac_underflow(uf12), .dac_enable(en12)
  );

  localparam logic [63:0] M12 = 64'hfff0_fff0_fff0_fff0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] lmask(int sw);
    logic [15:0] l;
    l = 16'hffff;
    l = l << (16 - sw);
    return {4{l}};
  endfunction

  function automatic logic [63:0] ramp_word(
    int b, logic [15:0] inc, int sw);
    logic [63:0] r;
    for (int i = 0; i < 4; i++)
      r[i*16+:16] = 16'((b * 4 + i) * int'(inc));
    return r & lmask(sw);
  endfunction

  // Beat 0 is the seed; beat b>=1 holds generated bits
  // (b-1)*W .. b*W-1 of b[m] = b[m-n] ^ b[m-t]
  function automatic logic [63:0] pn_word(
    int n, int t, int sw, int b, bit inv);
    bit s[1024];
    logic [63:0] r;
    int w;
    w = 4 * sw;
    r = '1;
    if (b > 0) begin
      r = '0;
      for (int m = 0; m < n; m++) s[m] = 1'b1;
      for (int m = n; m < n + b * w; m++)
        s[m] = s[m-n] ^ s[m-t];
      for (int k = 0; k < w; k++)
        r[(k / sw) * 16 + 15 - (k % sw)] =
          s[n + (b - 1) * w + k];
    end
    if (inv) r = ~r;
    return r & lmask(sw);
  endfunction

  function automatic int pn_n(int p);
    case (p)
      1: return 9;
      2: return 15;
      3: return 23;
      4: return 31;
      default: return 7;
    endcase
  endfunction

  function automatic int pn_t(int p);
    case (p)
      1: return 5;
      2: return 14;
      3: return 18;
      4: return 28;
      default: return 6;
    endcase
  endfunction

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dac16 !== '0 || dac12 !== '0 || en16 !== 1'b0 ||
        rdy16 !== 1'b0 || uf16 !== 1'b0) begin
      errors++;
      $display("FAIL reset: dac=%h en=%b rdy=%b uf=%b want 0",
               dac16, en16, rdy16, uf16);
    end
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    logic [63:0] e;
    sel = 4'd10;
    incr = 16'd1;
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    checks++;
    if (dac16 !== 64'h0003_0002_0001_0000) begin
      errors++;
      $display("FAIL ramp_beat1: got %h want 0003000200010000",
               dac16);
    end
    step();
    checks++;
    if (dac16 !== 64'h0007_0006_0005_0004) begin
      errors++;
      $display("FAIL ramp_beat2: got %h want 0007000600050004",
               dac16);
    end
    incr = 16'h4000;
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    step();
    checks++;
    if (dac16 !== 64'hc000_8000_4000_0000) begin
      errors++;
      $display("FAIL ramp_wrap: got %h want c000800040000000",
               dac16);
    end
    for (int r = 0; r < 3; r++) begin
      incr = 16'($urandom);
      sync = 1'b1;
      step();
      step();
      checks++;
      e = ramp_word(0, incr, 16);
      if (dac16 !== e) begin
        errors++;
        $display("FAIL ramp_sync_held: got %h want %h",
                 dac16, e);
      end
      sync = 1'b0;
      step();
      for (int b = 0; b < 3; b++) begin
        checks++;
        e = ramp_word(b, incr, 16);
        if (dac16 !== e || dac12 !== ramp_word(b, incr, 12))
        begin
          errors++;
          $display("FAIL ramp_rand: got %h/%h want %h", dac16,
                   dac12, e);
        end
        step();
      end
    end
  endtask

  task automatic run_pn(int code, int p);
    int n, t;
    bit inv;
    logic [63:0] e16, e12;
    inv = (code == 4 || code == 5 || code == 9);
    if (code == 4 || code == 6) p = 0;
    if (code == 5 || code == 7) p = 2;
    n = pn_n(p);
    t = pn_t(p);
    sel = 4'(code);
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    for (int b = 0; b < 4; b++) begin
      e16 = pn_word(n, t, 16, b, inv);
      e12 = pn_word(n, t, 12, b, inv);
      checks++;
      if (dac16 !== e16 || dac12 !== e12) begin
        errors++;
        $display("FAIL pn code%0d sel%0d beat%0d: got %h/%h want %h/%h",
                 code, p, b, dac16, dac12, e16, e12);
      end
      step();
    end
  endtask

  task automatic test_pn();
    int codes[6] = '{4, 5, 6, 7, 8, 9};
    int p;
    pn_sel = 3'd2;
    run_pn(8, 2);
    run_pn(9, 2);
    for (int r = 0; r < 6; r++) begin
      p = $urandom_range(0, 7);
      pn_sel = 3'(p);
      run_pn(codes[$urandom_range(0, 5)], p);
    end
    for (int p2 = 0; p2 < 5; p2++) begin
      pn_sel = 3'(p2);
      run_pn(8, p2);
    end
  endtask

  task automatic test_pattern();
    pat0 = 16'h1234;
    pat1 = 16'habcd;
    sel = 4'd1;
    step();
    checks++;
    if (dac12 !== 64'habc0_1230_abc0_1230 ||
        dac16 !== 64'habcd_1234_abcd_1234) begin
      errors++;
      $display("FAIL pattern: got %h/%h want abc01230abc01230",
               dac12, dac16);
    end
  endtask

  task automatic test_dds_zero();
    logic [63:0] d;
    for (int r = 0; r < 3; r++) begin
      d = {$urandom, $urandom};
      dds_data = d;
      sel = 4'd0;
      step();
      checks++;
      if (dac16 !== d || dac12 !== (d & M12)) begin
        errors++;
        $display("FAIL dds: got %h/%h want %h", dac16, dac12, d);
      end
      sel = 4'($urandom_range(11, 15));
      if (r == 0) sel = 4'd3;
      step();
      checks++;
      if (dac16 !== '0 || dac12 !== '0) begin
        errors++;
        $display("FAIL zero sel%0d: got %h want 0", sel, dac16);
      end
    end
  endtask

  task automatic test_underflow();
    logic [63:0] d1, d2;
    uf_clr = 1'b1;
    sel = 4'd2;
    uf_mode = 1'b0;
    step();
    uf_clr = 1'b0;
    d1 = {$urandom, $urandom};
    dma_data = d1;
    dma_valid = 1'b1;
    step();
    checks++;
    if (dac16 !== d1 || dac12 !== (d1 & M12) || uf16 !== 1'b0)
    begin
      errors++;
      $display("FAIL dma_beat: got %h uf=%b want %h uf=0",
               dac16, uf16, d1);
    end
    dma_valid = 1'b0;
    step();
    checks++;
    if (dac16 !== '0 || uf16 !== 1'b1 || uf12 !== 1'b1) begin
      errors++;
      $display("FAIL uf_zero: got %h uf=%b want 0 uf=1",
               dac16, uf16);
    end
    d2 = {$urandom, $urandom};
    dma_data = d2;
    dma_valid = 1'b1;
    uf_clr = 1'b1;
    step();
    uf_clr = 1'b0;
    checks++;
    if (dac16 !== d2 || uf16 !== 1'b0) begin
      errors++;
      $display("FAIL uf_clear: got %h uf=%b want %h uf=0",
               dac16, uf16, d2);
    end
    uf_mode = 1'b1;
    dma_valid = 1'b0;
    step();
    checks++;
    if (dac16 !== d2 || dac12 !== (d2 & M12) || uf16 !== 1'b1)
    begin
      errors++;
      $display("FAIL uf_hold: got %h uf=%b want %h uf=1",
               dac16, uf16, d2);
    end
    uf_clr = 1'b1;
    step();
    checks++;
    if (uf16 !== 1'b1 || dac16 !== d2) begin
      errors++;
      $display("FAIL uf_set_wins: uf=%b dac=%h want uf=1 %h",
               uf16, dac16, d2);
    end
    dma_valid = 1'b1;
    step();
    uf_clr = 1'b0;
    checks++;
    if (uf16 !== 1'b0) begin
      errors++;
      $display("FAIL uf_clr2: uf=%b want 0", uf16);
    end
  endtask

  task automatic test_switch();
    logic [63:0] last;
    sel = 4'd2;
    dma_valid = 1'b1;
    uf_mode = 1'b1;
    step();
    last = {$urandom, $urandom};
    dma_data = last;
    sel = 4'd3;
    #1;
    checks++;
    if (rdy16 !== 1'b1 || en16 !== 1'b1) begin
      errors++;
      $display("FAIL sw_ready_before: rdy=%b en=%b want 1",
               rdy16, en16);
    end
    step();
    checks++;
    if (rdy16 !== 1'b0 || en16 !== 1'b0 || rdy12 !== 1'b0 ||
        dac16 !== '0) begin
      errors++;
      $display("FAIL sw_to_zero: rdy=%b en=%b dac=%h want 0",
               rdy16, en16, dac16);
    end
    for (int i = 0; i < 3; i++) begin
      dma_data = {$urandom, $urandom};
      step();
    end
    sel = 4'd2;
    dma_valid = 1'b0;
    #1;
    checks++;
    if (rdy16 !== 1'b0) begin
      errors++;
      $display("FAIL sw_ready_lat: rdy=%b want 0", rdy16);
    end
    step();
    checks++;
    if (rdy16 !== 1'b1 || en16 !== 1'b1 || dac16 !== last) begin
      errors++;
      $display("FAIL sw_back: rdy=%b dac=%h want 1 %h",
               rdy16, dac16, last);
    end
    step();
  endtask

  task automatic test_async_reset();
    logic [63:0] e;
    sel = 4'd8;
    pn_sel = 3'd4;
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    step();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dac16 !== '0 || dac12 !== '0 || en16 !== 1'b0 ||
        rdy16 !== 1'b0 || uf16 !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: dac=%h en=%b uf=%b want 0",
               dac16, en16, uf16);
    end
    step();
    rst = 1'b0;
    sel = 4'd2;
    uf_mode = 1'b1;
    dma_valid = 1'b0;
    step();
    checks++;
    if (dac16 !== '0) begin
      errors++;
      $display("FAIL hold_reset: got %h want 0", dac16);
    end
    sel = 4'd8;
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    checks++;
    if (dac16 !== '1 || dac12 !== M12) begin
      errors++;
      $display("FAIL pn31_reseed: got %h want ffff..", dac16);
    end
    step();
    e = pn_word(31, 28, 16, 1, 1'b0);
    checks++;
    if (dac16 !== e) begin
      errors++;
      $display("FAIL pn31_beat1: got %h want %h", dac16, e);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_pn();
    test_pattern();
    test_dds_zero();
    test_underflow();
    test_switch();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_pattern_channel.md
# ad_ip_jesd204_tpl_dac_pattern_channel

Per-converter DAC transport-layer channel with a registered source mux. It selects between external DDS data, DMA data (valid/ready), fixed pattern, ramp, zero, and a parametrised parallel PRBS (PN7/9/15/23/31). It supports configurable sample resolution and samples per beat, and reports DMA underflow. One instance per converter sits between the DMA/DDS front end and the JESD204 framer.

## Interface
Parameters:
- DATA_PATH_WIDTH, 4, samples per clock beat (1..16).
- SAMPLE_WIDTH, 16, converter resolution (8..16); samples are MSB-justified in 16-bit lanes.

Ports:
- clk  in  1  converter/link clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- dma_data  in  DATA_PATH_WIDTH*16  DMA samples, sample 0 in the LSBs.
- dma_valid  in  1  dma_data valid.
- dma_ready  out  1  beat consumed when dma_valid && dma_ready.
- dds_data  in  DATA_PATH_WIDTH*16  external DDS samples.
- dac_data  out  DATA_PATH_WIDTH*16  channel output.
- dac_data_sync  in  1  reseeds the PRBS and the ramp.
- dac_data_sel  in  4  source select.
- dac_pn_sel  in  3  PRBS select for codes 8/9.
- dac_pat_data_0, dac_pat_data_1  in  16  fixed pattern words.
- dac_ramp_incr  in  16  ramp step per sample.
- dac_underflow_mode  in  1  0 = zeros on underflow, 1 = hold last DMA beat.
- dac_underflow_clr  in  1  clears the sticky underflow flag.
- dac_underflow  out  1  sticky underflow flag.
- dac_enable  out  1  high while the DMA source is selected.

## Operation
- Source codes for dac_data_sel:
  - 0 = DDS
  - 1 = pattern: even samples get pat_0, odd samples get pat_1
  - 2 = DMA
  - 3 = zero
  - 4 = ~PN7, 5 = ~PN15, 6 = PN7, 7 = PN15 (legacy codes)
  - 8 = PN selected by dac_pn_sel, 9 = its inverse
  - 10 = ramp
  - 11..15 = zero (reserved)
- dac_pn_sel values: 0 = PN7 (x^7+x^6+1), 1 = PN9 (x^9+x^5+1), 2 = PN15 (x^15+x^14+1), 3 = PN23 (x^23+x^18+1), 4 = PN31 (x^31+x^28+1). Values 5..7 select PN7.
- PRBS:
  - All five generators run every cycle, independent of the selected source.
  - Each cycle a generator advances by DATA_PATH_WIDTH*SAMPLE_WIDTH bits.
  - Stream bit k of a beat maps to sample k/SAMPLE_WIDTH, lane bit 15 - (k mod SAMPLE_WIDTH), so the oldest bit lands in the sample-0 MSB.
  - dac_data_sync loads every state register with all-ones.
- Ramp:
  - Sample i = base + i*incr (mod 2^16).
  - base advances by DATA_PATH_WIDTH*incr (mod 2^16) every cycle.
  - dac_data_sync sets base to 0.
- Resolution: for every source, lane bits [15-SAMPLE_WIDTH:0] are forced to 0 on dac_data when SAMPLE_WIDTH < 16.
- DMA handshake:
  - dma_ready equals dac_enable.
  - A ready cycle with dma_valid low is an underflow. dac_data then shows zero or the last accepted beat, per dac_underflow_mode.
  - Underflow sets dac_underflow. On the same cycle, set wins over dac_underflow_clr.
  - The last-beat hold register resets to 0.

## Timing
- Registered output: inputs sampled at edge n appear on dac_data after edge n. Latency is 1 for every source.
- dac_data_sel change at edge n: dac_enable and dma_ready update at n, and the new source is visible after n.
- dma_data is sampled on the same edge as dma_valid && dma_ready.
- Sync asserted at edge n:
  - The first output after edge n+1 is the seed word: 0xFFFF per lane for PN, masked by SAMPLE_WIDTH.
  - The ramp likewise shows sample i = i*incr after edge n+1.
  - Sync held high repeats the seed word.
- Reset values:
  - dac_data = 0, dac_enable = 0, dma_ready = 0, dac_underflow = 0.
  - PRBS states all-ones, ramp base 0, hold register 0.
- Reset asserted mid-stream forces all of the above immediately, without waiting for clk.

## Structure
- Shared package/include holds:
  - the dac_data_sel codes (localparams)
  - the dac_pn_sel codes
  - the polynomial tap constants
- Sub-module ad_ip_jesd204_tpl_dac_prbs:
  - Parameters POLY_ORDER, TAP, WIDTH (= DATA_PATH_WIDTH*SAMPLE_WIDTH).
  - Holds a POLY_ORDER-bit state register.
  - A parallel unrolled next-state function produces WIDTH bits per cycle.
  - Has a sync reload input.
  - Instantiated five times.
- Bit-to-lane mapping, ramp, underflow logic and the output mux stay in the top module.

## Test plan
- Ramp, DATA_PATH_WIDTH=4, SAMPLE_WIDTH=16, incr=1, sync pulse:
  - Beat 1 lanes {3,2,1,0} MSB→LSB.
  - Beat 2 lanes {7,6,5,4}.
  - With incr=0x4000, wraps back to 0 at sample 4.
- PN15 via code 8 (dac_pn_sel=2) after sync, then code 9:
  - First beat all lanes 0xFFFF.
  - Later beats match the bit-serial reference model under the stated mapping.
  - Code 9 output is the bitwise inverse.
- SAMPLE_WIDTH=12, pattern code 1, pat_0=0x1234, pat_1=0xABCD → lanes {0xABC0, 0x1230, 0xABC0, 0x1230}.
- DMA underflow:
  - Code 2, one beat of valid dropped with mode=0: that beat outputs 0 and dac_underflow=1.
  - Repeated with mode=1: outputs the previous beat.
  - Clear and set on the same cycle: the flag stays 1.
- Select switching: codes 2→3→2 → dma_ready and dac_enable follow with 1-cycle latency, and no DMA beat is consumed while code 3 is selected.
- Async reset asserted mid-PN31 output:
  - dac_data goes to 0 before the next clk edge.
  - After release, the next sync restarts the sequence at 0xFFFF.
